// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter unit.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,
    PC_REL  = 2'b01,
    PC_JALR = 2'b10,
    PC_RSVD = 2'b11
  } pcsrc_e;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/pc_unit_if.sv
// Control/redirect bundle between the pipeline (master) and the PC unit (slave).
interface pc_unit_if #(
  parameter int unsigned XLEN = 32
);

  logic            stall;
  logic            trap;
  logic [1:0]      PCsrc;
  logic [XLEN-1:0] BranchPC;
  logic [XLEN-1:0] ImmOp;
  logic [XLEN-1:0] JalrTarget;
  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] PCPlus4;
  logic            redirect;
  logic            misaligned;
  logic            pend_valid;

  modport master (
    output stall, trap, PCsrc, BranchPC, ImmOp, JalrTarget,
    input  PC, PCPlus4, redirect, misaligned, pend_valid
  );

  modport slave (
    input  stall, trap, PCsrc, BranchPC, ImmOp, JalrTarget,
    output PC, PCPlus4, redirect, misaligned, pend_valid
  );

endinterface

// File: rtl/pc_target_sel.sv
// Combinational redirect-target selection: aligned target plus misalignment flag.
module pc_target_sel
  import pc_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  pcsrc_e          pcsrc_i,
  input  logic [XLEN-1:0] branch_pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] jalr_target_i,
  output logic [XLEN-1:0] target_o,
  output logic            redirect_o,
  output logic            misaligned_o
);

  logic [XLEN-1:0] rel_sum;
  logic [XLEN-1:0] jalr_clr;

  assign rel_sum  = branch_pc_i + imm_i;
  assign jalr_clr = {jalr_target_i[XLEN-1:1], 1'b0};

  always_comb begin
    target_o     = '0;
    redirect_o   = 1'b0;
    misaligned_o = 1'b0;
    case (pcsrc_i)
      PC_REL: begin
        target_o     = {rel_sum[XLEN-1:2], 2'b00};
        redirect_o   = 1'b1;
        misaligned_o = |rel_sum[1:0];
      end
      PC_JALR: begin
        // Bit 0 is architecturally discarded, so only bit 1 can misalign.
        target_o     = {jalr_clr[XLEN-1:2], 2'b00};
        redirect_o   = 1'b1;
        misaligned_o = jalr_clr[1];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter with stall, trap, redirect and optional pending-redirect buffer.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN          = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR  = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR   = 32'h0000_0100,
  parameter bit              HOLD_REDIRECT = 1'b1
) (
  input logic       clk,
  input logic       rst,
  pc_unit_if.slave  bus
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            pend_valid_q, pend_valid_d;
  logic            redirect_q, redirect_d;

  logic [XLEN-1:0] target;
  logic            new_redirect;
  logic            mis_raw;
  logic [XLEN-1:0] pc_plus4;

  pc_target_sel #(
    .XLEN(XLEN)
  ) u_target_sel (
    .pcsrc_i      (pcsrc_e'(bus.PCsrc)),
    .branch_pc_i  (bus.BranchPC),
    .imm_i        (bus.ImmOp),
    .jalr_target_i(bus.JalrTarget),
    .target_o     (target),
    .redirect_o   (new_redirect),
    .misaligned_o (mis_raw)
  );

  assign pc_plus4 = pc_q + XLEN'(PC_INC);

  always_comb begin
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid_q;
    redirect_d   = 1'b0;
    if (bus.trap) begin
      pc_d         = TRAP_VECTOR;
      redirect_d   = 1'b1;
      pend_valid_d = 1'b0;
      pend_pc_d    = '0;
    end else if (new_redirect && (!bus.stall || !HOLD_REDIRECT)) begin
      // A fresh redirect supersedes anything still buffered.
      pc_d         = target;
      redirect_d   = 1'b1;
      pend_valid_d = 1'b0;
    end else if (new_redirect) begin
      pend_pc_d    = target;
      pend_valid_d = 1'b1;
    end else if (pend_valid_q && !bus.stall) begin
      pc_d         = pend_pc_q;
      redirect_d   = 1'b1;
      pend_valid_d = 1'b0;
    end else if (!bus.stall) begin
      pc_d = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_VECTOR;
      pend_pc_q    <= '0;
      pend_valid_q <= 1'b0;
      redirect_q   <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
      redirect_q   <= redirect_d;
    end
  end

  assign bus.PC         = pc_q;
  assign bus.PCPlus4    = pc_plus4;
  assign bus.redirect   = redirect_q;
  assign bus.pend_valid = pend_valid_q;
  assign bus.misaligned = mis_raw & ~bus.trap & ~rst;

endmodule

// File: tb/tb_pc_unit.sv
// Vector-table bench driving a buffered (HOLD_REDIRECT=1) and an immediate (=0) PC unit.
module tb_pc_unit;
  import pc_pkg::*;

  typedef struct {
    logic        rst, stall, trap;
    logic [1:0]  src;
    logic [31:0] bpc, imm, jt;
    logic        mis;
    logic [31:0] pc_h;
    logic        red_h, pend_h;
    logic [31:0] pc_n;
    logic        red_n;
  } vec_t;

  typedef struct {
    logic [31:0] pc_h;
    logic        red_h, pend_h;
    logic [31:0] pc_n;
    logic        red_n;
  } exp_t;

  localparam int NV = 28;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, trap;
  logic [1:0]  src;
  logic [31:0] bpc, imm, jt;

  int   passes = 0;
  int   total  = 0;
  exp_t sbq[$];
  vec_t vecs[NV];

  always #5 clk = ~clk;

  pc_unit_if #(.XLEN(32)) bus_h ();
  pc_unit_if #(.XLEN(32)) bus_n ();

  assign bus_h.stall = stall;      assign bus_n.stall = stall;
  assign bus_h.trap = trap;        assign bus_n.trap = trap;
  assign bus_h.PCsrc = src;        assign bus_n.PCsrc = src;
  assign bus_h.BranchPC = bpc;     assign bus_n.BranchPC = bpc;
  assign bus_h.ImmOp = imm;        assign bus_n.ImmOp = imm;
  assign bus_h.JalrTarget = jt;    assign bus_n.JalrTarget = jt;

  pc_unit #(
    .XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .HOLD_REDIRECT(1'b1)
  ) dut_h (
    .clk(clk), .rst(rst), .bus(bus_h)
  );

  pc_unit #(
    .XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .HOLD_REDIRECT(1'b0)
  ) dut_n (
    .clk(clk), .rst(rst), .bus(bus_n)
  );

  function automatic vec_t mk(logic r, logic s, logic t, logic [1:0] sr, logic [31:0] b,
                              logic [31:0] i, logic [31:0] j, logic m, logic [31:0] ph,
                              logic rh, logic pdh, logic [31:0] pn, logic rn);
    vec_t v;
    v.rst = r; v.stall = s; v.trap = t; v.src = sr; v.bpc = b; v.imm = i; v.jt = j;
    v.mis = m; v.pc_h = ph; v.red_h = rh; v.pend_h = pdh; v.pc_n = pn; v.red_n = rn;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic apply(string tag, vec_t v);
    exp_t e;
    rst = v.rst; stall = v.stall; trap = v.trap; src = v.src;
    bpc = v.bpc; imm = v.imm; jt = v.jt;
    #1;
    chk({tag, "_mis_h"}, 32'(bus_h.misaligned), 32'(v.mis));
    chk({tag, "_mis_n"}, 32'(bus_n.misaligned), 32'(v.mis));
    e.pc_h = v.pc_h; e.red_h = v.red_h; e.pend_h = v.pend_h;
    e.pc_n = v.pc_n; e.red_n = v.red_n;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk({tag, "_pc_h"}, bus_h.PC, e.pc_h);
    chk({tag, "_pc4_h"}, bus_h.PCPlus4, e.pc_h + 32'd4);
    chk({tag, "_red_h"}, 32'(bus_h.redirect), 32'(e.red_h));
    chk({tag, "_pend_h"}, 32'(bus_h.pend_valid), 32'(e.pend_h));
    chk({tag, "_pc_n"}, bus_n.PC, e.pc_n);
    chk({tag, "_red_n"}, 32'(bus_n.redirect), 32'(e.red_n));
    chk({tag, "_pend_n"}, 32'(bus_n.pend_valid), 32'd0);
  endtask

  initial begin
    //            rst  st   tr   src    BranchPC       ImmOp          JalrTgt     mis
    //            pc_h          rh   pdh  pc_n          rn
    vecs[0]  = mk(1, 0, 1, 2'b10, 32'h0,         32'h0,         32'h107,       0,
                  32'h0,         0, 0, 32'h0,         0);
    vecs[1]  = mk(1, 0, 0, 2'b00, 32'h0,         32'h0,         32'h0,         0,
                  32'h0,         0, 0, 32'h0,         0);
    vecs[2]  = mk(0, 0, 0, 2'b00, 32'h0,         32'h0,         32'h0,         0,
                  32'h4,         0, 0, 32'h4,         0);
    vecs[3]  = mk(0, 0, 0, 2'b00, 32'h0,         32'h0,         32'h0,         0,
                  32'h8,         0, 0, 32'h8,         0);
    vecs[4]  = mk(0, 0, 0, 2'b00, 32'h0,         32'h0,         32'h0,         0,
                  32'hC,         0, 0, 32'hC,         0);
    vecs[5]  = mk(0, 0, 0, 2'b01, 32'h20,        32'hFFFF_FFF0, 32'h0,         0,
                  32'h10,        1, 0, 32'h10,        1);
    vecs[6]  = mk(0, 0, 0, 2'b00, 32'h0,         32'h0,         32'h0,         0,
                  32'h14,        0, 0, 32'h14,        0);
    vecs[7]  = mk(0, 0, 0, 2'b10, 32'h0,         32'h0,         32'h107,       1,
                  32'h104,       1, 0, 32'h104,       1);
    vecs[8]  = mk(0, 0, 0, 2'b11, 32'h3,         32'h0,         32'h3,         0,
                  32'h108,       0, 0, 32'h108,       0);
    vecs[9]  = mk(0, 0, 0, 2'b01, 32'h1,         32'h40,        32'h0,         1,
                  32'h40,        1, 0, 32'h40,        1);
    vecs[10] = mk(0, 1, 0, 2'b00, 32'h0,         32'h0,         32'h0,         0,
                  32'h40,        0, 0, 32'h40,        0);
    vecs[11] = mk(0, 1, 0, 2'b01, 32'h40,        32'h40,        32'h0,         0,
                  32'h40,        0, 1, 32'h80,        1);
    vecs[12] = mk(0, 1, 0, 2'b00, 32'h0,         32'h0,         32'h0,         0,
                  32'h40,        0, 1, 32'h80,        0);
    vecs[13] = mk(0, 0, 0, 2'b00, 32'h0,         32'h0,         32'h0,         0,
                  32'h80,        1, 0, 32'h84,        0);
    vecs[14] = mk(0, 0, 0, 2'b00, 32'h0,         32'h0,         32'h0,         0,
                  32'h84,        0, 0, 32'h88,        0);
    vecs[15] = mk(0, 1, 0, 2'b01, 32'h100,       32'h100,       32'h0,         0,
                  32'h84,        0, 1, 32'h200,       1);
    vecs[16] = mk(0, 1, 0, 2'b10, 32'h0,         32'h0,         32'h301,       0,
                  32'h84,        0, 1, 32'h300,       1);
    vecs[17] = mk(0, 0, 0, 2'b00, 32'h0,         32'h0,         32'h0,         0,
                  32'h300,       1, 0, 32'h304,       0);
    vecs[18] = mk(0, 1, 0, 2'b01, 32'h400,       32'h100,       32'h0,         0,
                  32'h300,       0, 1, 32'h500,       1);
    vecs[19] = mk(0, 0, 0, 2'b10, 32'h0,         32'h0,         32'h600,       0,
                  32'h600,       1, 0, 32'h600,       1);
    vecs[20] = mk(0, 0, 0, 2'b00, 32'h0,         32'h0,         32'h0,         0,
                  32'h604,       0, 0, 32'h604,       0);
    vecs[21] = mk(0, 1, 0, 2'b01, 32'h700,       32'h0,         32'h0,         0,
                  32'h604,       0, 1, 32'h700,       1);
    vecs[22] = mk(0, 1, 1, 2'b10, 32'h0,         32'h0,         32'h107,       0,
                  32'h100,       1, 0, 32'h100,       1);
    vecs[23] = mk(0, 1, 0, 2'b00, 32'h0,         32'h0,         32'h0,         0,
                  32'h100,       0, 0, 32'h100,       0);
    vecs[24] = mk(0, 0, 0, 2'b00, 32'h0,         32'h0,         32'h0,         0,
                  32'h104,       0, 0, 32'h104,       0);
    vecs[25] = mk(0, 0, 0, 2'b01, 32'hFFFF_FFF0, 32'h20,        32'h0,         0,
                  32'h10,        1, 0, 32'h10,        1);
    vecs[26] = mk(0, 0, 0, 2'b10, 32'h0,         32'h0,         32'hFFFF_FFFD, 0,
                  32'hFFFF_FFFC, 1, 0, 32'hFFFF_FFFC, 1);
    vecs[27] = mk(0, 0, 0, 2'b00, 32'h0,         32'h0,         32'h0,         0,
                  32'h0,         0, 0, 32'h0,         0);

    for (int i = 0; i < NV; i++) apply($sformatf("v%0d", i), vecs[i]);

    // Reset must drop a buffered redirect; then a trap pulses redirect for one cycle only.
    apply("h_pend", mk(0, 1, 0, 2'b01, 32'h40, 32'h0, 32'h0, 0, 32'h0, 0, 1, 32'h40, 1));
    apply("h_rst",  mk(1, 1, 0, 2'b00, 32'h0,  32'h0, 32'h0, 0, 32'h0, 0, 0, 32'h0,  0));
    apply("h_rel",  mk(0, 0, 0, 2'b00, 32'h0,  32'h0, 32'h0, 0, 32'h4, 0, 0, 32'h4,  0));
    apply("h_trap", mk(0, 0, 1, 2'b01, 32'h1,  32'h0, 32'h0, 0, 32'h100, 1, 0, 32'h100, 1));
    apply("h_post", mk(0, 0, 0, 2'b00, 32'h0,  32'h0, 32'h0, 0, 32'h104, 0, 0, 32'h104, 0));

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the pipelined CPU; next generation of the single-cycle PC register.
- Holds the fetch PC and selects the next PC from four sources: sequential, PC-relative branch/JAL, JALR, and trap vector.
- Supports pipeline stalls, an optional pending-redirect buffer for redirects that arrive while stalled, and misaligned-target detection.
- Feeds instruction memory and the IF/ID register; takes redirects from the execute stage.

Parameters:
XLEN, 32, width of PC and all address/offset ports
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
TRAP_VECTOR, 32'h0000_0100, PC value loaded on trap
HOLD_REDIRECT, 1, 1: redirect during stall is buffered until stall drops; 0: redirect overrides stall immediately

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
stall  in  1  hold PC (hazard unit)
trap  in  1  take trap: next PC = TRAP_VECTOR, overrides stall
PCsrc  in  2  00 sequential, 01 relative (BranchPC+ImmOp), 10 JALR (JalrTarget), 11 reserved (treated as 00)
BranchPC  in  XLEN  PC of the redirecting instruction
ImmOp  in  XLEN  sign-extended branch/JAL offset
JalrTarget  in  XLEN  rs1+imm from ALU
PC  out  XLEN  current fetch PC (registered)
PCPlus4  out  XLEN  PC+4, combinational from PC
redirect  out  1  registered; 1 in the cycle after PC was loaded non-sequentially (IF/ID flush)
misaligned  out  1  combinational; request this cycle has target[1] set after JALR bit0 clear, or target[1:0]!=0 for relative
pend_valid  out  1  registered; a buffered redirect is waiting (always 0 when HOLD_REDIRECT=0)

Behaviour:
- Reset (rst=1 at edge) forces: PC=RESET_VECTOR, redirect=0, pend_valid=0, pending target cleared. All other inputs are ignored.
- Target computation:
  - Relative target = BranchPC+ImmOp, modulo 2^XLEN (wrap, no overflow flag).
  - JALR target = JalrTarget with bit0 cleared.
  - Loaded targets always have bits[1:0] forced to 0; misaligned is reported in the same cycle, but the PC still loads the aligned value.
- Next-PC priority per edge: rst > trap > new redirect (PCsrc 01/10) > pending redirect > stall hold > PC+4.
- trap=1:
  - PC=TRAP_VECTOR, redirect=1 next cycle, pending cleared.
  - Applies regardless of stall and PCsrc.
- Redirect, stall=0:
  - PC=target, redirect=1 next cycle.
  - Any pending redirect is discarded; the newer redirect wins.
- Redirect, stall=1, HOLD_REDIRECT=1:
  - PC holds.
  - Target is captured in the pending register, pend_valid=1; a later redirect while still stalled overwrites it.
- Redirect, stall=1, HOLD_REDIRECT=0: treated as stall=0 (PC=target, redirect=1).
- pend_valid=1, stall=0, no new redirect/trap:
  - PC=pending target, pend_valid=0, redirect=1 next cycle.
- stall=1, nothing pending: PC and pend_valid hold; redirect=0 next cycle.
- Sequential:
  - PC=PC+4 (wraps 0xFFFF_FFFC -> 0x0), redirect=0.
  - PCsrc=11 is treated as sequential and does not raise misaligned.
- Latency: one cycle from request to PC update; redirect pulse lasts exactly one cycle per non-sequential load.
- misaligned depends only on the current PCsrc/trap inputs. It is 0 when trap=1 or rst=1.

Decomposition:
- Package pc_pkg:
  - pcsrc_e enum (PC_SEQ=2'b00, PC_REL=2'b01, PC_JALR=2'b10, PC_RSVD=2'b11).
  - Constant PC_INC=4.
- One combinational sub-module, pc_target_sel:
  - Computes the aligned target and misaligned flag from PCsrc/BranchPC/ImmOp/JalrTarget.
- All state (PC, pending target, pend_valid, redirect) lives in pc_unit.

Test Plan:
- Reset, then sequential run: rst=1 for 2 cycles, then release -> PC=0x0,0x4,0x8,0xC on successive edges; redirect=0 throughout.
- Relative branch: BranchPC=0x20, ImmOp=0xFFFF_FFF0, PCsrc=01 for one cycle -> PC=0x10 next edge, redirect=1 for one cycle, then PC=0x14.
- JALR with misalign: JalrTarget=0x0000_0107, PCsrc=10 -> misaligned=1 that cycle; PC=0x104 next edge.
- Buffered redirect (HOLD_REDIRECT=1): stall=1 for 3 cycles at PC=0x40, PCsrc=01 target 0x80 in stall cycle 2 -> PC stays 0x40, pend_valid=1; first unstalled edge PC=0x80, pend_valid=0, redirect=1.
- Same stimulus with HOLD_REDIRECT=0 -> PC=0x80 at the stall-cycle-2 edge; pend_valid stays 0.
- Trap priority: trap=1 with stall=1, PCsrc=10, pend_valid=1 -> PC=0x100, pend_valid=0, redirect=1. Separately, rst=1 with trap=1 -> PC=0x0.
